// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank write-side logic.
// Register indices of the architecturally special registers and the writeback FSM encoding.
package regbank_pkg;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int NREGS = 16;

   localparam int REG_PC  = 0;
   localparam int REG_SP  = 1;
   localparam int REG_SR  = 2;
   localparam int REG_CG2 = 3;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_RES  = 2'd1,
      WB_PC   = 2'd2
   } wb_state_e;

   function automatic logic [NREGS-1:0] reg_onehot(input logic [AW-1:0] r);
      logic [NREGS-1:0] oh;
      oh    = '0;
      oh[r] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous result FIFO for the writeback sequencer; entries are {reg index, data}.
// Exposes per-entry occupancy and register index so the owner can build a pending-write mask.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 4,
   parameter int W     = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [W-1:0]              push_data,
   input  logic                      pop,
   output logic [W-1:0]              head,
   output logic                      full,
   output logic                      empty,
   output logic [DEPTH-1:0]          ent_vld,
   output logic [DEPTH-1:0][AW-1:0]  ent_reg
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign ent_reg[i] = mem[i][W-1 -: AW];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ent_vld <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr          <= wr_ptr + 1'b1;
            ent_vld[wr_ptr] <= 1'b1;
         end
         // push and pop never share a slot: push needs !full, pop needs !empty
         if (pop_ok) begin
            rd_ptr          <= rd_ptr + 1'b1;
            ent_vld[rd_ptr] <= 1'b0;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/regbank_writeback.sv
// Write-side sequencer for the register bank: arbitrates buffered ALU results against PC updates.
// Optional macro WB_R3_DISCARD_EN: results targeting r3 (CG2) are accepted but silently dropped.
module regbank_writeback #(
   parameter int DEPTH = 4,
   parameter int DW    = regbank_pkg::DW,
   parameter int AW    = regbank_pkg::AW
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          res_valid,
   output logic                          res_ready,
   input  logic [AW-1:0]                 res_reg,
   input  logic [DW-1:0]                 res_data,
   input  logic                          pc_req,
   input  logic [DW-1:0]                 pc_next,
   output logic                          wr_en,
   output logic [AW-1:0]                 wr_reg,
   output logic [DW-1:0]                 wr_data,
   output logic                          pc_inc,
   output logic [DW-1:0]                 pc_data_in,
   output logic [regbank_pkg::NREGS-1:0] pend_mask,
   output logic                          pc_drop,
   output logic                          idle
);

   import regbank_pkg::*;

   logic                     full;
   logic                     empty;
   logic [AW+DW-1:0]         head;
   logic [DEPTH-1:0]         ent_vld;
   logic [DEPTH-1:0][AW-1:0] ent_reg;

   wb_state_e                state;
   wb_state_e                nxt_state;
   logic                     pc_pend;
   logic [DW-1:0]            pc_val;

   logic                     accept;
   logic                     enq;
   logic                     enq_r0;
   logic                     pc_lost;
   logic                     pc_take;
   logic                     sel_pc;
   logic                     sel_res;

   assign res_ready = !full;
   assign accept    = res_valid && !full;

`ifdef WB_R3_DISCARD_EN
   assign enq = accept && (res_reg != AW'(REG_CG2));
`else
   assign enq = accept;
`endif

   assign enq_r0 = enq && (res_reg == AW'(REG_PC));

   // A queued or in-flight write to r0 is a branch; it must win over a sequential PC update.
   assign pc_lost = pc_req && (pend_mask[REG_PC] || enq_r0);
   assign pc_take = pc_req && !pc_lost;

   // Back-to-back PC grants are blocked while results wait, so neither source starves.
   assign sel_pc  = pc_pend && !((state == WB_PC) && !empty);
   assign sel_res = !empty && !sel_pc;

   always_comb begin
      nxt_state = WB_IDLE;
      if (sel_pc)       nxt_state = WB_PC;
      else if (sel_res) nxt_state = WB_RES;
   end

   wb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (AW + DW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (enq),
      .push_data ({res_reg, res_data}),
      .pop       (sel_res),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .ent_vld   (ent_vld),
      .ent_reg   (ent_reg)
   );

   // Stage boundary: grant decision registered onto the bank write/PC ports
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WB_IDLE;
         pc_pend    <= 1'b0;
         wr_en      <= 1'b0;
         wr_reg     <= '0;
         wr_data    <= '0;
         pc_inc     <= 1'b0;
         pc_data_in <= '0;
         pc_drop    <= 1'b0;
      end else begin
         state   <= nxt_state;
         wr_en   <= sel_res;
         pc_inc  <= sel_pc;
         pc_drop <= pc_lost;
         if (sel_res) {wr_reg, wr_data} <= head;
         if (sel_pc)  pc_data_in <= pc_val;
         if (pc_take)     pc_pend <= 1'b1;
         else if (enq_r0) pc_pend <= 1'b0;
         else if (sel_pc) pc_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (pc_take) pc_val <= pc_next;
   end

   // The bank samples its read ports on the commit edge, so the in-flight write still counts.
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) pend_mask = pend_mask | reg_onehot(ent_reg[i]);
      end
      if (wr_en) pend_mask = pend_mask | reg_onehot(wr_reg);
   end

   assign idle = empty && !pc_pend && (state == WB_IDLE);

endmodule

// File: tb/tb_regbank_writeback.sv
// Self-checking bench for regbank_writeback: directed scenarios then random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_regbank_writeback;

   localparam int DEPTH = 4;
`ifdef WB_R3_DISCARD_EN
   localparam bit DISCARD = 1'b1;
`else
   localparam bit DISCARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic [3:0]  res_reg = '0;
   logic [15:0] res_data = '0;
   logic        pc_req = 1'b0;
   logic [15:0] pc_next = '0;
   logic        wr_en;
   logic [3:0]  wr_reg;
   logic [15:0] wr_data;
   logic        pc_inc;
   logic [15:0] pc_data_in;
   logic [15:0] pend_mask;
   logic        pc_drop;
   logic        idle;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regbank_writeback #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_reg    (res_reg),
      .res_data   (res_data),
      .pc_req     (pc_req),
      .pc_next    (pc_next),
      .wr_en      (wr_en),
      .wr_reg     (wr_reg),
      .wr_data    (wr_data),
      .pc_inc     (pc_inc),
      .pc_data_in (pc_data_in),
      .pend_mask  (pend_mask),
      .pc_drop    (pc_drop),
      .idle       (idle)
   );

   // Reference model: pending results as a queue, a pending PC value, and who was granted last.
   logic [19:0] mq[$];
   bit          m_pend = 1'b0;
   logic [15:0] m_pcval = '0;
   bit          m_last_pc = 1'b0;
   bit          m_granted = 1'b0;
   logic        e_wr_en = 1'b0;
   logic [3:0]  e_wr_reg = '0;
   logic [15:0] e_wr_data = '0;
   logic        e_pc_inc = 1'b0;
   logic [15:0] e_pc_data = '0;
   logic        e_drop = 1'b0;

   function automatic logic [15:0] exp_mask();
      logic [15:0] m;
      m = '0;
      foreach (mq[i]) m[mq[i][19:16]] = 1'b1;
      if (e_wr_en) m[e_wr_reg] = 1'b1;
      return m;
   endfunction

   task automatic model_edge(input logic v, input logic [3:0] r, input logic [15:0] d,
                             input logic pr, input logic [15:0] pn, input logic rs);
      bit r0_pending, acc, enq, lost;
      int grant;
      if (rs) begin
         mq.delete();
         m_pend = 1'b0;
         m_last_pc = 1'b0;
         m_granted = 1'b0;
         e_wr_en = 1'b0; e_wr_reg = '0; e_wr_data = '0;
         e_pc_inc = 1'b0; e_pc_data = '0; e_drop = 1'b0;
      end else begin
         r0_pending = e_wr_en && (e_wr_reg == 4'd0);
         foreach (mq[i]) if (mq[i][19:16] == 4'd0) r0_pending = 1'b1;
         acc = v && (mq.size() < DEPTH);
         if (m_pend && !(m_last_pc && mq.size() > 0)) grant = 2;
         else if (mq.size() > 0)                      grant = 1;
         else                                         grant = 0;
         e_wr_en  = (grant == 1);
         e_pc_inc = (grant == 2);
         if (grant == 1) {e_wr_reg, e_wr_data} = mq.pop_front();
         if (grant == 2) e_pc_data = m_pcval;
         enq  = acc && !(DISCARD && r == 4'd3);
         lost = pr && (r0_pending || (enq && r == 4'd0));
         e_drop = lost;
         if (pr && !lost)            begin m_pend = 1'b1; m_pcval = pn; end
         else if (enq && r == 4'd0)  m_pend = 1'b0;
         else if (grant == 2)        m_pend = 1'b0;
         if (enq) mq.push_back({r, d});
         m_last_pc = (grant == 2);
         m_granted = (grant != 0);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("res_ready", res_ready, mq.size() < DEPTH);
      chk("wr_en", wr_en, e_wr_en);
      chk("wr_reg", wr_reg, e_wr_reg);
      chk("wr_data", wr_data, e_wr_data);
      chk("pc_inc", pc_inc, e_pc_inc);
      chk("pc_data_in", pc_data_in, e_pc_data);
      chk("pend_mask", pend_mask, exp_mask());
      chk("pc_drop", pc_drop, e_drop);
      chk("idle", idle, (mq.size() == 0) && !m_pend && !m_granted);
      chk("strobe_excl", wr_en & pc_inc, 1'b0);
   endtask

   task automatic step(input logic v, input logic [3:0] r, input logic [15:0] d,
                       input logic pr, input logic [15:0] pn, input logic rs);
      @(negedge clk);
      res_valid = v; res_reg = r; res_data = d;
      pc_req = pr; pc_next = pn; rst = rs;
      model_edge(v, r, d, pr, pn, rs);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle_step();
      step(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0);
   endtask

   initial begin
      // reset state
      step(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b1);
      step(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b1);
      chk("rst_ready", res_ready, 1'b1);
      chk("rst_idle", idle, 1'b1);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_mask", pend_mask, 16'h0);

      // single result r5
      step(1'b1, 4'd5, 16'h1234, 1'b0, 16'h0, 1'b0);
      idle_step();
      chk("single_wr_en", wr_en, 1'b1);
      chk("single_wr_reg", wr_reg, 4'd5);
      chk("single_wr_data", wr_data, 16'h1234);
      idle_step();
      chk("single_wr_en_off", wr_en, 1'b0);
      idle_step();

      // pc_req and result on the same edge
      step(1'b1, 4'd4, 16'h00AA, 1'b1, 16'h0002, 1'b0);
      idle_step();
      chk("pcfirst_pc_inc", pc_inc, 1'b1);
      chk("pcfirst_pc_data", pc_data_in, 16'h0002);
      idle_step();
      chk("pcfirst_wr_en", wr_en, 1'b1);
      chk("pcfirst_wr_reg", wr_reg, 4'd4);
      idle_step();

      // five back-to-back results
      for (int i = 0; i < 5; i++) step(1'b1, 4'(6 + i), 16'(16'h0A00 + i), 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 3; i++) idle_step();

      // pc_req every cycle with results arriving: grants alternate
      for (int i = 0; i < 3; i++) step(1'b1, 4'(1 + i), 16'(16'h0B00 + i), 1'b1, 16'(16'h0100 + 2*i), 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 16'h0, 1'b1, 16'(16'h0200 + 2*i), 1'b0);
      for (int i = 0; i < 2; i++) idle_step();

      // branch write to r0 queued, then a sequential pc_req
      step(1'b1, 4'd0, 16'h0100, 1'b0, 16'h0, 1'b0);
      step(1'b0, 4'd0, 16'h0, 1'b1, 16'h0004, 1'b0);
      chk("r0_drop", pc_drop, 1'b1);
      chk("r0_wr_en", wr_en, 1'b1);
      chk("r0_wr_reg", wr_reg, 4'd0);
      chk("r0_wr_data", wr_data, 16'h0100);
      idle_step();
      chk("r0_no_pc_inc", pc_inc, 1'b0);
      chk("r0_drop_pulse", pc_drop, 1'b0);
      idle_step();
      chk("r0_no_pc_inc2", pc_inc, 1'b0);

      // fill the FIFO under pc_req pressure, then reset with entries queued
      for (int i = 0; i < 6; i++) step(1'b1, 4'(8 + i), 16'(16'h0C00 + i), 1'b1, 16'(16'h0300 + 2*i), 1'b0);
      chk("fill_ready_low", res_ready, 1'b0);
      step(1'b1, 4'd14, 16'h0CFF, 1'b1, 16'h0400, 1'b0);
      step(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b1);
      chk("midrst_wr_en", wr_en, 1'b0);
      chk("midrst_mask", pend_mask, 16'h0);
      chk("midrst_idle", idle, 1'b1);
      chk("midrst_pc_inc", pc_inc, 1'b0);
      idle_step();

      // write to r3 (CG2)
      step(1'b1, 4'd3, 16'hBEEF, 1'b0, 16'h0, 1'b0);
      chk("r3_mask", pend_mask[3], !DISCARD);
      idle_step();
      chk("r3_wr_en", wr_en, !DISCARD);
      idle_step();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), 16'($urandom),
              $urandom_range(0, 99) < 25, 16'($urandom), $urandom_range(0, 199) == 0);
      end
      for (int i = 0; i < 8; i++) idle_step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
